// File: rtl/imem_debug_loader_pkg.sv
// Shared types and constants for the instruction-memory debug loader.
// Imported by the loader RTL and its bench.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    VERIFY,
    DONE,
    ERROR
  } state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_off(
    input logic [31:0] idx
  );
    return idx * WORD_BYTES;
  endfunction

endpackage

// File: rtl/imem_debug_loader.sv
// Streams a program image into instruction memory over the debug port,
// reads it back, checks the additive checksum and then releases the core.
module imem_debug_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             debug_en,
  output logic             debug_write_en,
  output logic [31:0]      debug_addr,
  output logic [31:0]      debug_data_in,
  input  logic [31:0]      debug_data_out,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wc_q;
  logic [CNT_W-1:0] idx_q;
  logic [31:0]      rsum_q;
  logic [31:0]      rsum_nx;
  logic             hs;
  logic             len_ok;
  logic             last;

  assign hs      = in_valid & in_ready;
  assign len_ok  = (word_count != '0) &&
                   (32'(word_count) <= MAX_WORDS);
  assign last    = idx_q == wc_q - CNT_W'(1);
  // readback sum including the word on the bus this cycle
  assign rsum_nx = rsum_q + debug_data_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) state_d = len_ok ? LOAD : ERROR;
        end
        LOAD: begin
          if (hs && last) state_d = DRAIN;
        end
        DRAIN: state_d = VERIFY;
        VERIFY: begin
          if (last) begin
            state_d = (rsum_nx == checksum) ? DONE : ERROR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      DRAIN, VERIFY: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      DONE: done = 1'b1;
      ERROR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      debug_en       <= 1'b0;
      debug_write_en <= 1'b0;
      debug_addr     <= '0;
      debug_data_in  <= '0;
      checksum       <= '0;
      rsum_q         <= '0;
      wc_q           <= '0;
      idx_q          <= '0;
    end else if (abort) begin
      debug_en       <= 1'b0;
      debug_write_en <= 1'b0;
      debug_addr     <= '0;
      debug_data_in  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            debug_en       <= len_ok;
            debug_write_en <= 1'b0;
            debug_addr     <= BASE_ADDR;
            debug_data_in  <= '0;
            checksum       <= '0;
            rsum_q         <= '0;
            wc_q           <= word_count;
            idx_q          <= '0;
          end
        end
        LOAD: begin
          debug_en       <= 1'b1;
          debug_write_en <= hs;
          if (hs) begin
            debug_addr    <= BASE_ADDR + word_off(32'(idx_q));
            debug_data_in <= in_data;
            checksum      <= checksum + in_data;
            idx_q         <= idx_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          // the index is reused to walk the readback
          debug_en       <= 1'b1;
          debug_write_en <= 1'b0;
          debug_addr     <= BASE_ADDR;
          debug_data_in  <= '0;
          rsum_q         <= '0;
          idx_q          <= '0;
        end
        VERIFY: begin
          rsum_q <= rsum_nx;
          if (last) begin
            debug_en   <= 1'b0;
            debug_addr <= '0;
          end else begin
            debug_addr <= debug_addr + WORD_BYTES;
            idx_q      <= idx_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_debug_loader.sv
// Bench for imem_debug_loader: behavioural memory, vector table,
// random stream gaps and hand-written abort/reset sequences.
module tb_imem_debug_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] word_count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        debug_en;
  logic        debug_write_en;
  logic [31:0] debug_addr;
  logic [31:0] debug_data_in;
  logic [31:0] debug_data_out;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  imem_debug_loader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .word_count     (word_count),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .debug_en       (debug_en),
    .debug_write_en (debug_write_en),
    .debug_addr     (debug_addr),
    .debug_data_in  (debug_data_in),
    .debug_data_out (debug_data_out),
    .cpu_hold       (cpu_hold),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic        mem_init;
  logic        bd_we;
  logic [31:0] bd_data;
  int unsigned wr_cnt = 0;

  assign debug_data_out = mem[debug_addr[10:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= NOP_INSTR;
    end else begin
      if (debug_en && debug_write_en)
        mem[debug_addr[10:2]] <= debug_data_in;
      if (bd_we) mem[1] <= bd_data;
    end
    if (debug_en && debug_write_en) wr_cnt <= wr_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // {in_ready, busy, cpu_hold, done, error}
  task automatic status(input string nm, input logic [4:0] exp);
    chk(nm, {27'b0, in_ready, busy, cpu_hold, done, error},
        {27'b0, exp});
  endtask

  task automatic dbg_zero(input string nm);
    chk(nm, debug_addr | debug_data_in |
            {30'b0, debug_en, debug_write_en}, 32'h0);
  endtask

  typedef struct {
    int n;
    int stall_at;
    int stall_len;
    bit rnd;
    bit corrupt;
    bit fixed;
    int exp_edge;
  } vec_t;

  vec_t tbl[9];

  task automatic run_load(input vec_t v);
    logic [31:0] w[$];
    logic [31:0] img[4];
    logic [31:0] sum;
    logic [31:0] want;
    int k, gaps, gap_left, edge_i, fin, e_last;
    int hold_bad, mism;
    int unsigned wr0;
    bit vld, hs;
    img = '{32'h00000013, 32'h00100093,
            32'h00208113, 32'hCAFEBABE};
    sum = '0;
    for (int i = 0; i < v.n; i++) begin
      w.push_back(v.fixed ? img[i % 4] : $urandom);
      sum += w[i];
    end
    wr0 = wr_cnt;
    start = 1'b1;
    word_count = 16'(v.n);
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_clr_sum", checksum, 32'h0);
    status("load_status", 5'b11100);
    k = 0; gaps = 0; gap_left = v.stall_len;
    edge_i = 0; fin = -1; e_last = -10; hold_bad = 0;
    while (fin < 0 && edge_i < 8 * v.n + 60) begin
      if (k < v.n) begin
        if (v.rnd) vld = ($urandom_range(0, 3) != 0);
        else if (k == v.stall_at && gap_left > 0) begin
          vld = 1'b0;
          gap_left--;
        end else vld = 1'b1;
        in_valid = vld;
        in_data = vld ? w[k] : $urandom;
        if (!vld) gaps++;
      end else begin
        in_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data = $urandom;
        start = v.rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        word_count = 16'($urandom);
      end
      bd_we = v.corrupt && k == v.n && edge_i == e_last + 1;
      hs = in_valid && in_ready;
      @(posedge clk);
      edge_i++;
      if (hs) begin
        k++;
        if (k == v.n) e_last = edge_i;
      end
      @(negedge clk);
      if (done || error) fin = edge_i;
      else if (!cpu_hold) hold_bad++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    bd_we = 1'b0;
    chk("finish_edge", fin, 2 * v.n + gaps + 1);
    if (v.exp_edge != 0) chk("table_edge", fin, v.exp_edge);
    chk("done_level", done, !v.corrupt);
    chk("error_level", error, v.corrupt);
    chk("hold_release", cpu_hold, v.corrupt);
    chk("hold_during", hold_bad, 0);
    chk("busy_end", busy, 1'b0);
    chk("checksum", checksum, sum);
    chk("wr_pulses", wr_cnt - wr0, v.n);
    dbg_zero("dbg_after");
    mism = 0;
    for (int i = 0; i < v.n; i++) begin
      want = (v.corrupt && i == 1) ? 32'hDEADBEEF : w[i];
      if (mem[i] !== want) mism++;
    end
    chk("mem_image", mism, 0);
  endtask

  task automatic bad_len(input int n);
    int unsigned wr0;
    wr0 = wr_cnt;
    start = 1'b1;
    word_count = 16'(n);
    @(negedge clk);
    start = 1'b0;
    status("badlen_status", 5'b00101);
    chk("badlen_en", debug_en, 1'b0);
    repeat (3) @(negedge clk);
    status("badlen_hold", 5'b00101);
    chk("badlen_writes", wr_cnt - wr0, 0);
  endtask

  logic [31:0] w0, w1;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    word_count = '0; in_valid = 1'b0; in_data = '0;
    mem_init = 1'b1; bd_we = 1'b0;
    bd_data = 32'hDEADBEEF;
    tbl[0] = '{4, -1, 0, 0, 0, 1, 9};
    tbl[1] = '{4, 2, 3, 0, 0, 1, 12};
    tbl[2] = '{4, -1, 0, 0, 1, 1, 9};
    tbl[3] = '{1, -1, 0, 0, 0, 0, 3};
    tbl[4] = '{256, -1, 0, 0, 0, 0, 513};
    for (int i = 5; i < 9; i++)
      tbl[i] = '{$urandom_range(1, 12), -1, 0, 1, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    status("rst_status", 5'b00000);
    dbg_zero("rst_dbg");
    chk("rst_sum", checksum, 32'h0);
    mem_init = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_load(tbl[i]);

    bad_len(0);
    bad_len(257);

    // abort after two words
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    w0 = $urandom;
    w1 = $urandom;
    start = 1'b1;
    word_count = 16'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = w0;
    @(negedge clk);
    in_data = w1;
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    status("abort_status", 5'b00000);
    dbg_zero("abort_dbg");
    chk("abort_sum", checksum, w0 + w1);
    repeat (2) @(negedge clk);
    chk("abort_mem0", mem[0], w0);
    chk("abort_mem1", mem[1], w1);
    chk("abort_mem2", mem[2], NOP_INSTR);

    // abort beats a simultaneous start
    start = 1'b1;
    abort = 1'b1;
    word_count = 16'd4;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    status("abort_wins", 5'b00000);

    // reset while verifying
    start = 1'b1;
    word_count = 16'd4;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    status("mid_verify", 5'b01100);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    status("rstv_status", 5'b00000);
    dbg_zero("rstv_dbg");
    chk("rstv_sum", checksum, 32'h0);
    run_load('{8, -1, 0, 0, 0, 0, 17});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
